// File: rtl/rpn_pkg.sv
// Shared encodings for the RPN stack sequencer: command opcodes, error codes, FSM states.
package rpn_pkg;

  localparam logic CMD_PUSH    = 1'b0;
  localparam logic CMD_OPERATE = 1'b1;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_OVF  = 2'b01;
  localparam logic [1:0] ERR_UNF  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PUSH_WR = 3'd1,
    ST_RD_B    = 3'd2,
    ST_CAP_B   = 3'd3,
    ST_CAP_A   = 3'd4,
    ST_EXEC    = 3'd5,
    ST_WR_RES  = 3'd6,
    ST_ERROR   = 3'd7
  } state_t;

endpackage

// File: rtl/reg_load_enable.sv
// Data register with synchronous active-high reset and load enable.
module reg_load_enable #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)     q <= '0;
    else if (load) q <= d;
  end

endmodule

// File: rtl/rpn_stack_sequencer.sv
// RPN calculator controller: owns the stack pointer and sequences stack RAM and ALU.
// Build option RPN_STICKY_ERR_EN: errors latch in ERROR until reset instead of pulsing.
module rpn_stack_sequencer
  import rpn_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned OP_W   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [OP_W-1:0]   cmd_alu_sel,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] top_value,
  output logic [ADDR_W:0]   depth,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam int unsigned DEPTH   = 2 ** ADDR_W;
  localparam int unsigned DEPTH_W = ADDR_W + 1;

  state_t state, state_nxt;

  logic [ADDR_W-1:0]  ram_addr_nxt;
  logic [DATA_W-1:0]  ram_wdata_nxt;
  logic               ram_wren_nxt;
  logic [OP_W-1:0]    alu_op_nxt;
  logic [DATA_W-1:0]  top_value_nxt;
  logic [DEPTH_W-1:0] depth_nxt;
  logic               done_nxt;
  logic               err_nxt;
  logic [1:0]         err_code_nxt;

  logic accept_c, ovf_c, unf_c, err_hit_c, load_a_c, load_b_c;

  assign cmd_ready = (state == ST_IDLE);
  assign accept_c  = cmd_valid && cmd_ready;
  assign ovf_c     = (depth == DEPTH_W'(DEPTH));
  assign unf_c     = (depth < DEPTH_W'(2));
  assign err_hit_c = accept_c && (((cmd_op == CMD_PUSH) && ovf_c) ||
                                  ((cmd_op == CMD_OPERATE) && unf_c));
  assign load_b_c  = (state == ST_CAP_B);
  assign load_a_c  = (state == ST_CAP_A);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (err_hit_c) begin
`ifdef RPN_STICKY_ERR_EN
          state_nxt = ST_ERROR;
`else
          state_nxt = ST_IDLE;
`endif
        end else if (accept_c) begin
          state_nxt = (cmd_op == CMD_PUSH) ? ST_PUSH_WR : ST_RD_B;
        end
      end
      ST_PUSH_WR: state_nxt = ST_IDLE;
      ST_RD_B:    state_nxt = ST_CAP_B;
      ST_CAP_B:   state_nxt = ST_CAP_A;
      ST_CAP_A:   state_nxt = ST_EXEC;
      ST_EXEC:    state_nxt = ST_WR_RES;
      ST_WR_RES:  state_nxt = ST_IDLE;
      ST_ERROR:   state_nxt = ST_ERROR;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; pulses default low, everything else holds.
  always_comb begin
    ram_addr_nxt  = ram_addr;
    ram_wdata_nxt = ram_wdata;
    ram_wren_nxt  = 1'b0;
    alu_op_nxt    = alu_op;
    top_value_nxt = top_value;
    depth_nxt     = depth;
    done_nxt      = 1'b0;
`ifdef RPN_STICKY_ERR_EN
    err_nxt       = err;
    err_code_nxt  = err_code;
`else
    err_nxt       = 1'b0;
    err_code_nxt  = ERR_NONE;
`endif
    case (state)
      ST_IDLE: begin
        if (err_hit_c) begin
          err_nxt      = 1'b1;
          err_code_nxt = (cmd_op == CMD_PUSH) ? ERR_OVF : ERR_UNF;
        end else if (accept_c) begin
          if (cmd_op == CMD_PUSH) begin
            ram_addr_nxt  = ADDR_W'(depth);
            ram_wdata_nxt = cmd_data;
            ram_wren_nxt  = 1'b1;
          end else begin
            ram_addr_nxt  = ADDR_W'(depth - DEPTH_W'(1));
            alu_op_nxt    = cmd_alu_sel;
          end
        end
      end
      ST_PUSH_WR: begin
        depth_nxt     = depth + DEPTH_W'(1);
        top_value_nxt = ram_wdata;
        done_nxt      = 1'b1;
      end
      ST_RD_B: ram_addr_nxt = ADDR_W'(depth - DEPTH_W'(2));
      ST_EXEC: begin
        ram_wdata_nxt = alu_result;
        ram_wren_nxt  = 1'b1;
      end
      ST_WR_RES: begin
        depth_nxt     = depth - DEPTH_W'(1);
        top_value_nxt = ram_wdata;
        done_nxt      = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_wren  <= 1'b0;
      alu_op    <= '0;
      top_value <= '0;
      depth     <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      ram_addr  <= ram_addr_nxt;
      ram_wdata <= ram_wdata_nxt;
      ram_wren  <= ram_wren_nxt;
      alu_op    <= alu_op_nxt;
      top_value <= top_value_nxt;
      depth     <= depth_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
      err_code  <= err_code_nxt;
    end
  end

  // Top of stack is read first, so alu_b loads one cycle before alu_a.
  reg_load_enable #(.DATA_W(DATA_W)) u_alu_b (
    .clk   (clk),
    .reset (reset),
    .load  (load_b_c),
    .d     (ram_q),
    .q     (alu_b)
  );

  reg_load_enable #(.DATA_W(DATA_W)) u_alu_a (
    .clk   (clk),
    .reset (reset),
    .load  (load_a_c),
    .d     (ram_q),
    .q     (alu_a)
  );

endmodule

// File: tb/tb_rpn_stack_sequencer.sv
// Directed bench for rpn_stack_sequencer with a behavioural stack RAM and ALU.
module tb_rpn_stack_sequencer;
  import rpn_pkg::*;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned OP_W   = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_op = 1'b0;
  logic [DATA_W-1:0] cmd_data = '0;
  logic [OP_W-1:0]   cmd_alu_sel = '0;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_wren;
  logic [DATA_W-1:0] ram_q = '0;
  logic [DATA_W-1:0] alu_a, alu_b;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] top_value;
  logic [ADDR_W:0]   depth;
  logic              done, err;
  logic [1:0]        err_code;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int wr_cyc = 0;
  int done_cnt = 0;
  int acc_cyc = 0;
  int w0 = 0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

  rpn_stack_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OP_W(OP_W)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_alu_sel(cmd_alu_sel),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wren(ram_wren), .ram_q(ram_q),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .top_value(top_value), .depth(depth), .done(done), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  // Single-port RAM, one-cycle read latency
  always @(posedge clk) begin
    if (ram_wren) mem[ram_addr] <= ram_wdata;
    ram_q <= mem[ram_addr];
  end

  always_comb begin
    case (alu_op)
      3'b000:  alu_result = alu_a + alu_b;
      3'b001:  alu_result = alu_a - alu_b;
      default: alu_result = alu_a & alu_b;
    endcase
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (ram_wren) begin
      wr_cnt  = wr_cnt + 1;
      wr_cyc  = cyc;
      wr_addr = ram_addr;
    end
    if (done) done_cnt = done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic op, input logic [DATA_W-1:0] data, input logic [OP_W-1:0] sel);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk("send_timeout", 32'(cmd_ready), 32'd1);
    cmd_op = op; cmd_data = data; cmd_alu_sel = sel; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk("idle_timeout", 32'(cmd_ready), 32'd1);
  endtask

  task automatic push(input logic [DATA_W-1:0] data);
    send(CMD_PUSH, data, '0);
    wait_idle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_depth", 32'(depth), 32'd0);
    chk("rst_top", 32'(top_value), 32'd0);
    chk("rst_wren", 32'(ram_wren), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_code", 32'(err_code), 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    reset = 1'b0;

    push(8'h05);
    chk("push1_done", 32'(done), 32'd1);
    push(8'h03);
    @(negedge clk);
    chk("push_mem0", 32'(mem[0]), 32'h05);
    chk("push_mem1", 32'(mem[1]), 32'h03);
    chk("push_depth", 32'(depth), 32'd2);
    chk("push_top", 32'(top_value), 32'h03);
    chk("push_done_cnt", 32'(done_cnt), 32'd2);

    send(CMD_OPERATE, '0, 3'b000);
    @(negedge clk);
    chk("op_rd_b_addr", 32'(ram_addr), 32'd1);
    @(negedge clk);
    chk("op_rd_a_addr", 32'(ram_addr), 32'd0);
    wait_idle();
    chk("op_alu_b", 32'(alu_b), 32'h03);
    chk("op_alu_a", 32'(alu_a), 32'h05);
    chk("op_mem0", 32'(mem[0]), 32'h08);
    chk("op_wr_addr", 32'(wr_addr), 32'd0);
    chk("op_wr_latency", 32'(wr_cyc - acc_cyc), 32'd5);
    chk("op_depth", 32'(depth), 32'd1);
    chk("op_top", 32'(top_value), 32'h08);
    chk("op_done", 32'(done), 32'd1);

    w0 = wr_cnt;
    send(CMD_OPERATE, '0, 3'b000);
    @(negedge clk);
    chk("unf_err", 32'(err), 32'd1);
    chk("unf_code", 32'(err_code), 32'(ERR_UNF));
    chk("unf_wren", 32'(ram_wren), 32'd0);
    chk("unf_depth", 32'(depth), 32'd1);
    chk("unf_done", 32'(done), 32'd0);
    @(negedge clk);
`ifdef RPN_STICKY_ERR_EN
    chk("unf_sticky_err", 32'(err), 32'd1);
    chk("unf_sticky_code", 32'(err_code), 32'(ERR_UNF));
    repeat (4) @(negedge clk);
    chk("unf_sticky_ready", 32'(cmd_ready), 32'd0);
    chk("unf_no_write", 32'(wr_cnt - w0), 32'd0);
    do_reset();
    chk("unf_reset_ready", 32'(cmd_ready), 32'd1);
    chk("unf_reset_err", 32'(err), 32'd0);
`else
    chk("unf_pulse_err", 32'(err), 32'd0);
    chk("unf_pulse_code", 32'(err_code), 32'(ERR_NONE));
    chk("unf_no_write", 32'(wr_cnt - w0), 32'd0);
    push(8'h07);
    chk("unf_push_depth", 32'(depth), 32'd2);
    chk("unf_push_top", 32'(top_value), 32'h07);
    chk("unf_push_mem1", 32'(mem[1]), 32'h07);
`endif

    do_reset();
    for (int i = 0; i < 2 ** ADDR_W; i++) push(DATA_W'(i));
    chk("fill_depth", 32'(depth), 32'd256);
    chk("fill_top", 32'(top_value), 32'hFF);
    chk("fill_mem255", 32'(mem[255]), 32'hFF);
    chk("fill_mem0", 32'(mem[0]), 32'h00);
    w0 = wr_cnt;
    send(CMD_PUSH, 8'hAA, '0);
    @(negedge clk);
    chk("ovf_err", 32'(err), 32'd1);
    chk("ovf_code", 32'(err_code), 32'(ERR_OVF));
    chk("ovf_depth", 32'(depth), 32'd256);
    chk("ovf_top", 32'(top_value), 32'hFF);
    @(negedge clk);
    chk("ovf_no_write", 32'(wr_cnt - w0), 32'd0);
    chk("ovf_mem0", 32'(mem[0]), 32'h00);

    do_reset();
    push(8'hFF);
    push(8'h02);
    send(CMD_OPERATE, '0, 3'b000);
    wait_idle();
    chk("wrap_top", 32'(top_value), 32'h01);
    chk("wrap_depth", 32'(depth), 32'd1);
    chk("wrap_mem0", 32'(mem[0]), 32'h01);

    push(8'h05);
    push(8'h03);
    w0 = wr_cnt;
    send(CMD_OPERATE, '0, 3'b001);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_depth", 32'(depth), 32'd0);
    chk("midrst_top", 32'(top_value), 32'd0);
    chk("midrst_wren", 32'(ram_wren), 32'd0);
    chk("midrst_ready", 32'(cmd_ready), 32'd1);
    chk("midrst_done", 32'(done), 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrst_no_write", 32'(wr_cnt - w0), 32'd0);
    chk("midrst_mem2", 32'(mem[2]), 32'h03);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rpn_stack_sequencer.md
Name: rpn_stack_sequencer

Overview:
Controller for the RPN calculator datapath: single-port synchronous stack RAM (8-bit data, 1-cycle read latency) plus combinational ALU.
- Accepts PUSH and OPERATE commands over a valid/ready handshake.
- Owns the stack pointer and sequences RAM address, write and read cycles, operand capture and result write-back.
- Detects overflow and underflow.
- Sits between the key/switch front-end FSM and the stack/ALU instances in rpn.

Parameters:
DATA_W, 8, stack word and ALU operand width
ADDR_W, 8, RAM address width; stack capacity DEPTH = 2**ADDR_W entries
OP_W, 3, ALU opcode width

Ports:
clk  in  1  system clock; single clock domain
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept; high only in IDLE
cmd_op  in  1  0 = PUSH, 1 = OPERATE
cmd_data  in  DATA_W  operand for PUSH
cmd_alu_sel  in  OP_W  ALU opcode for OPERATE
ram_addr  out  ADDR_W  stack RAM address (registered)
ram_wdata  out  DATA_W  stack RAM write data (registered)
ram_wren  out  1  stack RAM write enable (registered)
ram_q  in  DATA_W  stack RAM read data, valid 1 cycle after address sampled
alu_a  out  DATA_W  first operand (lower stack entry)
alu_b  out  DATA_W  second operand (top of stack)
alu_op  out  OP_W  registered ALU opcode
alu_result  in  DATA_W  ALU combinational output
top_value  out  DATA_W  cached top of stack; 0 when empty
depth  out  ADDR_W+1  number of entries, 0..DEPTH
done  out  1  one-cycle pulse when a command completes
err  out  1  error flag
err_code  out  2  00 none, 01 overflow, 10 underflow

Behaviour:
- Reset: state IDLE; depth 0; top_value 0; ram_addr, ram_wdata, alu_op, alu_a and alu_b all 0; ram_wren, done and err 0; err_code 00.
- Reset takes priority over everything. A reset mid-operation abandons the command with no write. RAM contents are not cleared, but the stack is logically empty.
- Handshake: a command is accepted on an edge where cmd_valid && cmd_ready. cmd_ready = (state == IDLE). Inputs are sampled only at acceptance.
- Stack layout: entries occupy addresses 0..depth-1. The top of stack is at depth-1.
- States:
  - IDLE
  - PUSH_WR
  - RD_B
  - CAP_B
  - CAP_A
  - EXEC
  - WR_RES
  - ERROR (feature only)
- PUSH, accepted at edge E0, with depth < DEPTH:
  - E0: ram_addr <= depth, ram_wdata <= cmd_data, ram_wren <= 1; state -> PUSH_WR.
  - E1: RAM writes; ram_wren <= 0, depth++, top_value <= data, done <= 1; state -> IDLE.
  - A new command can be accepted at E2.
- OPERATE, accepted at E0, with depth >= 2:
  - E0: ram_addr <= depth-1, alu_op <= cmd_alu_sel; state -> RD_B.
  - E1: ram_addr <= depth-2; state -> CAP_B.
  - E2: alu_b <= ram_q; state -> CAP_A.
  - E3: alu_a <= ram_q; state -> EXEC.
  - E4: ram_wdata <= alu_result, ram_wren <= 1 (address still depth-2); state -> WR_RES.
  - E5: write occurs; ram_wren <= 0, depth--, top_value <= result, done <= 1; state -> IDLE.
- Arithmetic: result is truncated to DATA_W with no carry or flags. Address arithmetic is done on ADDR_W+1 bits, then truncated.
- Boundary conditions:
  - PUSH with depth == DEPTH: overflow.
  - OPERATE with depth < 2: underflow.
  - On error: no RAM write; depth and top_value unchanged; done stays 0.
- Back-to-back: cmd_valid held high in IDLE is accepted on the same edge the previous done is asserted? No: done asserts on the edge returning to IDLE, so the next acceptance is the following edge.

Optional Feature:
Macro: RPN_STICKY_ERR_EN
- Defined:
  - An error moves the FSM to ERROR, with err = 1 and err_code held.
  - cmd_ready = 0 until reset.
- Undefined:
  - err pulses for exactly one cycle (the cycle after the offending acceptance), with err_code valid that cycle and cleared to 00 afterward.
  - The FSM stays in IDLE and the command is dropped.

Decomposition:
- Package rpn_pkg holds:
  - cmd_op encoding constants CMD_PUSH and CMD_OPERATE.
  - FSM state enum.
  - err_code constants ERR_NONE, ERR_OVF and ERR_UNF.
- Operand capture reuses the existing reg_load_enable (parameter DATA_W) for alu_a and alu_b.
- No new sub-module.

Test Plan:
- Reset, then PUSH 8'h05 and PUSH 8'h03: RAM[0]=05, RAM[1]=03; depth=2; top_value=03; two done pulses.
- From that state, OPERATE with bench ALU 000 = add: reads addr 1 then 0; alu_b=03, alu_a=05; write RAM[0]=08 exactly 5 edges after acceptance; depth=1; top_value=08.
- OPERATE with depth=1: err_code=10, no ram_wren, depth stays 1.
  - Without RPN_STICKY_ERR_EN: err is a 1-cycle pulse and a following PUSH 8'h07 succeeds.
  - With RPN_STICKY_ERR_EN: cmd_ready stays 0 until reset.
- Fill the stack with 256 PUSHes (ADDR_W=8), then PUSH again: overflow err_code=01; depth=256 unchanged.
- Wrap truncation: PUSH FF, PUSH 02, add: result 01, top_value=01.
- Assert reset during CAP_A: next cycle depth=0, top_value=0, ram_wren=0, cmd_ready=1; no write to RAM.
